// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state codes, switch priority order and debounce length shared by run_ctrl
// Switch indices double as priority order: lower index wins when edges coincide.
package run_ctrl_pkg;
  typedef enum logic [2:0] {
    HALTED   = 3'd0,
    CLEARING = 3'd1,
    RUNNING  = 3'd2,
    STEPI    = 3'd3,
    STEPM    = 3'd4
  } state_t;
  localparam int SW_CLEAR = 0;
  localparam int SW_HALT  = 1;
  localparam int SW_RUN   = 2;
  localparam int SW_STEPI = 3;
  localparam int SW_STEPM = 4;
  localparam int NUM_SW   = 5;
  localparam int DB_LEN   = 16;
  // Keeps only the lowest set bit, i.e. the highest-priority edge.
  function automatic logic [NUM_SW-1:0] first_edge(input logic [NUM_SW-1:0] e);
    return e & (-e);
  endfunction
endpackage

// File: rtl/sw_sync_edge.sv
// sw_sync_edge: two-flop synchroniser, optional debouncer and registered rising-edge detector for one panel switch
// Ports: SYSCLK clock, RESETn sync active-low reset, sw raw async switch, rise one-cycle edge pulse.
// Macro RUN_CTRL_DEBOUNCE_EN inserts a DB_LEN-sample debouncer after the synchroniser.
// A switch already high when reset is released never produces an edge: the valid
// shift register holds off edge reporting until the pipeline reflects real samples.
module sw_sync_edge
  import run_ctrl_pkg::*;
(
  input  logic SYSCLK,
  input  logic RESETn,
  input  logic sw,
  output logic rise
);
  logic s1, s2, lv, d;
  logic [3:0] v;
`ifdef RUN_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DB_LEN);
  logic db;
  logic [CW-1:0] cnt;
  // Until the synchroniser is valid the debounced level is simply loaded, so it starts settled.
  always_ff @(posedge SYSCLK)
    if (!RESETn) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (!v[2] || s2 == db || cnt == CW'(DB_LEN - 1)) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  assign lv = db;
`else
  assign lv = s2;
`endif
  always_ff @(posedge SYSCLK)
    if (!RESETn) begin
      {s1, s2, d, rise} <= '0;
      v <= '0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      d    <= lv;
      v    <= {v[2:0], 1'b1};
      rise <= lv & ~d & v[3];
    end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: PDP-8 front-panel run/step sequencer gating the CPU microcycle advance
// Ports: SYSCLK clock, RESETn sync active-low reset, sw_CLEAR/RUN/HALT/STEPM/STEPI async panel
// switches, cpu_instDone/cpu_hlt from the CPU; mcyc_en advance pulse, cpu_clear, running lamp,
// state code (0 HALTED,1 CLEARING,2 RUNNING,3 STEPI,4 STEPM).
// Macro RUN_CTRL_DEBOUNCE_EN enables switch debouncing inside sw_sync_edge.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic       SYSCLK,
  input  logic       RESETn,
  input  logic       sw_CLEAR,
  input  logic       sw_RUN,
  input  logic       sw_HALT,
  input  logic       sw_STEPM,
  input  logic       sw_STEPI,
  input  logic       cpu_instDone,
  input  logic       cpu_hlt,
  output logic       mcyc_en,
  output logic       cpu_clear,
  output logic       running,
  output logic [2:0] state
);
  logic [NUM_SW-1:0] sw, rise, sel;
  state_t st, nxt;
  logic [7:0] div_cnt;
  logic [3:0] clr_cnt;
  logic halt_req, stepping;
  assign sw = {sw_STEPM, sw_STEPI, sw_RUN, sw_HALT, sw_CLEAR};
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_sync_edge u_sw (
      .SYSCLK (SYSCLK),
      .RESETn (RESETn),
      .sw     (sw[i]),
      .rise   (rise[i])
    );
  end
  assign sel      = first_edge(rise);
  assign stepping = st inside {RUNNING, STEPI, STEPM};
  assign mcyc_en  = stepping && div_cnt == 8'(CLK_DIV - 1);
  assign state    = st;
  always_comb begin
    nxt = st;
    case (st)
      HALTED:   nxt = sel[SW_RUN] ? RUNNING : sel[SW_STEPI] ? STEPI : sel[SW_STEPM] ? STEPM : HALTED;
      CLEARING: nxt = clr_cnt == 4'(CLEAR_CYCLES - 1) ? HALTED : CLEARING;
      RUNNING:  nxt = mcyc_en && cpu_instDone && (halt_req || cpu_hlt) ? HALTED : RUNNING;
      STEPI:    nxt = mcyc_en && cpu_instDone ? HALTED : STEPI;
      STEPM:    nxt = mcyc_en ? HALTED : STEPM;
      default:  nxt = HALTED;
    endcase
    if (sel[SW_CLEAR]) nxt = CLEARING;
  end
  always_ff @(posedge SYSCLK)
    if (!RESETn) begin
      st        <= HALTED;
      div_cnt   <= '0;
      clr_cnt   <= '0;
      halt_req  <= 1'b0;
      cpu_clear <= 1'b0;
      running   <= 1'b0;
    end else begin
      st        <= nxt;
      // Divider restarts on every state entry so the first pulse lands CLK_DIV cycles in.
      div_cnt   <= (nxt == st && stepping && !mcyc_en) ? div_cnt + 1'b1 : '0;
      clr_cnt   <= (st == CLEARING && !sel[SW_CLEAR]) ? clr_cnt + 1'b1 : '0;
      // Request survives only while RUNNING continues; the stop itself or a CLEAR drops it.
      halt_req  <= nxt == RUNNING && (halt_req || (st == RUNNING && sel[SW_HALT]));
      cpu_clear <= nxt == CLEARING;
      running   <= nxt == RUNNING;
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized scoreboard bench for run_ctrl with a 3-microcycle CPU model
module tb_run_ctrl;
  localparam int CLK_DIV = 4;
  localparam int CLEAR_CYCLES = 4;
  localparam int HOLD = 24;
  localparam int GAP = 40;
`ifdef RUN_CTRL_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif
  localparam logic [4:0] M_CLR = 5'b00001, M_HLT = 5'b00010, M_RUN = 5'b00100,
                         M_SI = 5'b01000, M_SM = 5'b10000;

  logic SYSCLK = 0, RESETn = 0;
  logic [4:0] swv = '0;
  logic cpu_instDone, cpu_hlt, mcyc_en, cpu_clear, running;
  logic [2:0] state;

  run_ctrl #(.CLK_DIV(CLK_DIV), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .SYSCLK(SYSCLK), .RESETn(RESETn),
    .sw_CLEAR(swv[0]), .sw_HALT(swv[1]), .sw_RUN(swv[2]), .sw_STEPI(swv[3]), .sw_STEPM(swv[4]),
    .cpu_instDone(cpu_instDone), .cpu_hlt(cpu_hlt),
    .mcyc_en(mcyc_en), .cpu_clear(cpu_clear), .running(running), .state(state)
  );

  always #5 SYSCLK = ~SYSCLK;

  // CPU model: 3 microcycles per instruction, optional HLT on a chosen instruction.
  int uc = 0, inst = 0, npulse = 0, hlt_at = 0;
  logic hlt_on = 0;
  assign cpu_instDone = (uc == 2);
  assign cpu_hlt = hlt_on && inst == hlt_at;
  always @(posedge SYSCLK) begin
    if (mcyc_en) npulse <= npulse + 1;
    if (!RESETn || cpu_clear) uc <= 0;
    else if (mcyc_en) begin
      uc <= (uc + 1) % 3;
      if (uc == 2) inst <= inst + 1;
    end
  end

  // Expected response: the state entered, plus statistics of the segment just left.
  typedef struct {int st; int dur; int pulses; int clr; int run;} ev_t;
  ev_t sb[$];
  ev_t e;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  int prev_st, dur, pulses, clr_c, run_c, last_pulse, cyc = 0;
  always @(negedge SYSCLK) begin
    cyc++;
    if (!RESETn) begin
      prev_st = 0; dur = 0; pulses = 0; clr_c = 0; run_c = 0; last_pulse = -1;
    end else if (int'(state) != prev_st) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_transition: got state %0d after %0d, required no change", state, prev_st);
      end else begin
        e = sb.pop_front();
        chk("next_state", int'(state), e.st);
        if (e.dur >= 0) chk("segment_cycles", dur, e.dur);
        chk("segment_pulses", pulses, e.pulses);
        chk("segment_clear_cycles", clr_c, e.clr);
        chk("segment_running_cycles", run_c, e.run);
      end
      prev_st = int'(state); dur = 1;
      pulses = int'(mcyc_en); clr_c = int'(cpu_clear); run_c = int'(running);
      last_pulse = mcyc_en ? cyc : -1;
    end else begin
      dur++;
      pulses += int'(mcyc_en); clr_c += int'(cpu_clear); run_c += int'(running);
      if (mcyc_en) begin
        if (last_pulse >= 0) chk("pulse_spacing", cyc - last_pulse, CLK_DIV);
        last_pulse = cyc;
      end
    end
  end

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 3000) begin
      @(negedge SYSCLK);
      c++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d responses pending, required 0", sb.size());
      sb.delete();
    end
    repeat (GAP) @(negedge SYSCLK);
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    @(negedge SYSCLK);
    swv = swv | m;
    repeat (hold) @(negedge SYSCLK);
    swv = swv & ~m;
    drain();
  endtask

  // HALT raised during the k-th pulse of a run: the stop happens at the first instruction
  // boundary whose pulse comes after the HALT request has had time to propagate.
  task automatic run_halt(input int k);
    int stop = k + 1;
    int base = npulse;
    int th = -1;
    int c = 0;
    while (CLK_DIV * (stop - k) + 1 < LAT + 2 || stop % 3 != 0) stop++;
    sb.push_back('{2, -1, 0, 0, 0});
    sb.push_back('{0, stop * CLK_DIV, stop, 0, stop * CLK_DIV});
    @(negedge SYSCLK);
    swv[2] = 1;
    while ((sb.size() != 0 || th < 0 || c <= th + HOLD) && c < 3000) begin
      @(negedge SYSCLK);
      c++;
      if (c == HOLD) swv[2] = 0;
      if (th < 0 && mcyc_en && npulse - base == k - 1) begin
        swv[1] = 1;
        th = c;
      end else if (th >= 0 && c == th + HOLD) swv[1] = 0;
    end
    swv[2] = 0;
    swv[1] = 0;
    drain();
  endtask

  task automatic hlt_run(input int n);
    hlt_at = inst + n - 1;
    hlt_on = 1;
    sb.push_back('{2, -1, 0, 0, 0});
    sb.push_back('{0, 3 * n * CLK_DIV, 3 * n, 0, 3 * n * CLK_DIV});
    press(M_RUN, HOLD);
    hlt_on = 0;
  endtask

  task automatic steps(input int m);
    for (int i = 0; i < m; i++) begin
      sb.push_back('{4, -1, 0, 0, 0});
      sb.push_back('{0, CLK_DIV, 1, 0, 0});
      press(M_SM, HOLD);
    end
    sb.push_back('{3, -1, 0, 0, 0});
    sb.push_back('{0, (3 - m) * CLK_DIV, 3 - m, 0, 0});
    press(M_SI, HOLD);
  endtask

  initial begin
    swv = '1;
    RESETn = 0;
    repeat (2) @(posedge SYSCLK);
    @(negedge SYSCLK);
    chk("reset_state", int'(state), 0);
    chk("reset_mcyc_en", int'(mcyc_en), 0);
    chk("reset_cpu_clear", int'(cpu_clear), 0);
    chk("reset_running", int'(running), 0);
    RESETn = 1;
    repeat (GAP) @(negedge SYSCLK);
    swv = '0;
    repeat (GAP) @(negedge SYSCLK);
    chk("post_reset_state", int'(state), 0);

    sb.push_back('{1, -1, 0, 0, 0});
    sb.push_back('{0, CLEAR_CYCLES, 0, CLEAR_CYCLES, 0});
    press(M_CLR, 50);

    press(M_HLT, HOLD);

    for (int i = 0; i < 4; i++) run_halt($urandom_range(1, 9));

    hlt_run(5);
    hlt_run($urandom_range(1, 4));

    steps(1);
    for (int i = 0; i < 2; i++) steps($urandom_range(0, 2));

    sb.push_back('{1, -1, 0, 0, 0});
    sb.push_back('{0, CLEAR_CYCLES, 0, CLEAR_CYCLES, 0});
    press(M_CLR | M_RUN, HOLD);
    chk("clear_beats_run_state", int'(state), 0);

`ifdef RUN_CTRL_DEBOUNCE_EN
    press(M_RUN, 5);
    chk("glitch_state", int'(state), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end
endmodule
